// File: rtl/stack_sequencer_if.sv
// ROM fetch and stack RAM bus between the sequencer and its memories.
interface stack_sequencer_if #(
  parameter int unsigned DEPTH_BITS = 8,
  parameter int unsigned PC_BITS    = 8
);
  logic [PC_BITS-1:0]    ROM_ADDR;
  logic [15:0]           ROM_DATA;
  logic [DEPTH_BITS-1:0] RAM_ADDR;
  logic [31:0]           RAM_WDATA;
  logic                  RAM_WE;
  logic [31:0]           RAM_RDATA;

  modport master (
    output ROM_ADDR, RAM_ADDR, RAM_WDATA, RAM_WE,
    input  ROM_DATA, RAM_RDATA
  );

  modport slave (
    input  ROM_ADDR, RAM_ADDR, RAM_WDATA, RAM_WE,
    output ROM_DATA, RAM_RDATA
  );
endinterface

// File: rtl/stack_sequencer.sv
// Stack processor instruction sequencer: fetches 16-bit instructions from ROM once per
// instruction tick and executes them against a stack whose top item lives in a register
// and whose lower items live in an external single-port RAM.
module stack_sequencer #(
  parameter int unsigned INSTRUCTION_CLOCK_BIT = 22,
  parameter int unsigned DEPTH_BITS            = 8,
  parameter int unsigned PC_BITS               = 8
) (
  input  logic                CLK,
  input  logic                RST,
  stack_sequencer_if.master   bus,
  output logic [31:0]         STACK_TOP_ITEM,
  output logic [31:0]         STACK_ITEM_COUNT,
  output logic [PC_BITS-1:0]  PC,
  output logic                HALTED,
  output logic                FAULT
);

  localparam int unsigned CntW = DEPTH_BITS + 1;
  localparam logic [CntW-1:0] MaxCount = {1'b1, {DEPTH_BITS{1'b0}}};

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpPush = 4'h1;
  localparam logic [3:0] OpPop  = 4'h2;
  localparam logic [3:0] OpAdd  = 4'h3;
  localparam logic [3:0] OpSub  = 4'h4;
  localparam logic [3:0] OpDup  = 4'h5;
  localparam logic [3:0] OpJmp  = 4'h7;
  localparam logic [3:0] OpJz   = 4'h8;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StFetch  = 3'd1,
    StDecode = 3'd2,
    StRdwait = 3'd3,
    StExec   = 3'd4,
    StHalt   = 3'd5,
    StFlt    = 3'd6
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         div_q, div_d;
  logic                div_bit_q, div_bit_d;
  logic [PC_BITS-1:0]  pc_q, pc_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [31:0]         tos_q, tos_d;
  logic [15:0]         instr_q, instr_d;
  logic                halted_q, halted_d;
  logic                fault_q, fault_d;

  logic                  tick;
  logic [3:0]            op;
  logic [31:0]           imm;
  logic [PC_BITS-1:0]    pc_inc;
  logic                  needs_read;
  logic                  fail;
  logic [DEPTH_BITS-1:0] ram_addr;
  logic                  ram_we;

  assign tick   = div_q[INSTRUCTION_CLOCK_BIT] & ~div_bit_q;
  assign op     = instr_q[15:12];
  assign imm    = {20'd0, instr_q[11:0]};
  assign pc_inc = pc_q + PC_BITS'(1);

  // Opcodes that take the second item from RAM, when there is one to take.
  always_comb begin
    needs_read = 1'b0;
    if (cnt_q >= CntW'(2)) begin
      case (bus.ROM_DATA[15:12])
        OpPop, OpAdd, OpSub, OpJz: needs_read = 1'b1;
        default:                   needs_read = 1'b0;
      endcase
    end
  end

  // State and datapath registers; reset aborts any instruction in flight.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= StIdle;
      div_q     <= '0;
      div_bit_q <= 1'b0;
      pc_q      <= '0;
      cnt_q     <= '0;
      tos_q     <= '0;
      instr_q   <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      div_bit_q <= div_bit_d;
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      tos_q     <= tos_d;
      instr_q   <= instr_d;
      halted_q  <= halted_d;
      fault_q   <= fault_d;
    end
  end

  // Next-state, stack update and RAM strobes for each phase of an instruction.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q + 32'd1;
    div_bit_d = div_q[INSTRUCTION_CLOCK_BIT];
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    tos_d     = tos_q;
    instr_d   = instr_q;
    halted_d  = halted_q;
    fault_d   = fault_q;
    ram_addr  = '0;
    ram_we    = 1'b0;
    fail      = 1'b0;

    unique case (state_q)
      StIdle:   if (tick) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: begin
        instr_d = bus.ROM_DATA;
        state_d = needs_read ? StRdwait : StExec;
      end
      StRdwait: begin
        ram_addr = DEPTH_BITS'(cnt_q - CntW'(2));
        state_d  = StExec;
      end
      StExec: begin
        state_d = StIdle;
        case (op)
          OpNop: pc_d = pc_inc;
          OpPush: begin
            if (cnt_q == MaxCount) begin
              fail = 1'b1;
            end else begin
              // With an empty stack the TOS register is free, so nothing spills to RAM.
              ram_we   = (cnt_q != '0);
              ram_addr = DEPTH_BITS'(cnt_q - CntW'(1));
              tos_d    = imm;
              cnt_d    = cnt_q + CntW'(1);
              pc_d     = pc_inc;
            end
          end
          OpPop: begin
            if (cnt_q == '0) begin
              fail = 1'b1;
            end else begin
              tos_d = (cnt_q >= CntW'(2)) ? bus.RAM_RDATA : 32'd0;
              cnt_d = cnt_q - CntW'(1);
              pc_d  = pc_inc;
            end
          end
          OpAdd, OpSub: begin
            if (cnt_q < CntW'(2)) begin
              fail = 1'b1;
            end else begin
              tos_d = (op == OpAdd) ? bus.RAM_RDATA + tos_q : bus.RAM_RDATA - tos_q;
              cnt_d = cnt_q - CntW'(1);
              pc_d  = pc_inc;
            end
          end
          OpDup: begin
            if (cnt_q == '0 || cnt_q == MaxCount) begin
              fail = 1'b1;
            end else begin
              ram_we   = 1'b1;
              ram_addr = DEPTH_BITS'(cnt_q - CntW'(1));
              cnt_d    = cnt_q + CntW'(1);
              pc_d     = pc_inc;
            end
          end
          OpJmp: pc_d = imm[PC_BITS-1:0];
          OpJz: begin
            if (cnt_q == '0) begin
              fail = 1'b1;
            end else begin
              pc_d  = (tos_q == 32'd0) ? imm[PC_BITS-1:0] : pc_inc;
              tos_d = (cnt_q >= CntW'(2)) ? bus.RAM_RDATA : 32'd0;
              cnt_d = cnt_q - CntW'(1);
            end
          end
          OpHalt: begin
            halted_d = 1'b1;
            state_d  = StHalt;
          end
          default: fail = 1'b1;
        endcase
        if (fail) begin
          fault_d = 1'b1;
          state_d = StFlt;
        end
      end
      StHalt:   state_d = StHalt;
      StFlt:    state_d = StFlt;
      default:  state_d = StIdle;
    endcase
  end

  assign bus.ROM_ADDR  = pc_q;
  assign bus.RAM_ADDR  = ram_addr;
  assign bus.RAM_WDATA = tos_q;
  assign bus.RAM_WE    = ram_we;

  assign STACK_TOP_ITEM   = (cnt_q == '0) ? 32'd0 : tos_q;
  assign STACK_ITEM_COUNT = 32'(cnt_q);
  assign PC               = pc_q;
  assign HALTED           = halted_q;
  assign FAULT            = fault_q;

endmodule

// File: doc/stack_sequencer.md
Name: stack_sequencer

Overview:
- Instruction sequencer for the stack processor. Fetches 16-bit instructions from an external ROM and decodes them.
- Executes each instruction against an external single-port stack RAM. Holds the top-of-stack item in a register; the RAM holds all items below it.
- Advances one instruction per instruction tick, derived from a free-running divider bit.
- Exports the top item and item count so `main` can drive its observation ports directly.

Parameters:
- INSTRUCTION_CLOCK_BIT, 22: divider bit whose rising edge starts an instruction. Must be >=2; benches use 2.
- DEPTH_BITS, 8: stack RAM address width. Max stack items = 2^DEPTH_BITS (RAM entries plus the TOS register).
- PC_BITS, 8: ROM address width.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  asynchronous, active-high reset.
- ROM_ADDR  out  PC_BITS  instruction address.
- ROM_DATA  in  16  instruction word, valid 1 cycle after ROM_ADDR.
- RAM_ADDR  out  DEPTH_BITS  stack RAM address.
- RAM_WDATA  out  32  write data.
- RAM_WE  out  1  write strobe, single cycle.
- RAM_RDATA  in  32  read data, valid 1 cycle after RAM_ADDR (WE=0).
- STACK_TOP_ITEM  out  32  cached top item; 0 when count=0.
- STACK_ITEM_COUNT  out  32  items on stack.
- PC  out  PC_BITS  current program counter.
- HALTED  out  1  HALT executed; sticky.
- FAULT  out  1  overflow, underflow or illegal opcode; sticky.

Behaviour:
- Reset (async): divider, PC, count, TOS, RAM_WE, HALTED, FAULT = 0; ROM_ADDR = 0; state = IDLE.
- Tick: one-cycle pulse when divider bit INSTRUCTION_CLOCK_BIT goes 0->1. The divider is a 32-bit up-counter from reset, so the first tick occurs at cycle 2^B after reset release.
- States:
  - IDLE: on tick go to FETCH. Ticks are ignored in every other state and in HALT/FLT.
  - FETCH: ROM_ADDR=PC.
  - DECODE: latch ROM_DATA, where op=[15:12] and imm=[11:0], zero-extended to 32 bits.
  - RDWAIT: issue RAM read of RAM[count-2]; data is used next cycle.
  - EXEC: update state, then go to IDLE.
  - HALT, FLT: terminal until reset.
- Worst-case instruction latency is 4 cycles (FETCH, DECODE, RDWAIT, EXEC). This fits within a tick period of 2^(B+1) >= 8 cycles.
- Opcodes (c = count, T = TOS):
  - 0 NOP: PC+1.
  - 1 PUSH imm: if c>0, write T to RAM[c-1]; T=imm; c+1.
  - 2 POP: if c>=2, read RAM[c-2] into T; if c=1, T=0; c-1.
  - 3 ADD, 4 SUB: needs c>=2; read S=RAM[c-2]; T=S+T or S-T, 32-bit wrap; c-1.
  - 5 DUP: needs c>=1; write T to RAM[c-1]; c+1.
  - 7 JMP imm: PC=imm[PC_BITS-1:0].
  - 8 JZ imm: needs c>=1; if T==0 then PC=imm, else PC+1; then pops exactly as POP.
  - F HALT: HALTED=1, go to HALT; PC is unchanged.
  - Any other opcode goes to FLT.
- PC increments by 1 for every non-branch opcode and wraps modulo 2^PC_BITS.
- Underflow (requirement on c not met) or overflow (PUSH/DUP with c = 2^DEPTH_BITS): FAULT=1, go to FLT. Stack, PC and RAM are left unmodified.
- RAM_WE is asserted only in EXEC, for exactly one cycle. A RAM read and a RAM write never occur in the same instruction.
- Reset asserted mid-instruction aborts it immediately. No further RAM_WE is issued after RST rises.

Test Plan:
- Program PUSH 5, PUSH 7, ADD, HALT with B=2 -> after 4 ticks TOP=12, COUNT=1, HALTED=1; RAM[0]=5 was written once.
- PUSH 3, PUSH 10, SUB, HALT -> TOP=0xFFFFFFF9, COUNT=1.
- PUSH 0, JZ 4, PUSH 9, HALT, PUSH 1, HALT -> TOP=1, COUNT=1, PC=5; PUSH 9 is never executed.
- POP with an empty stack -> FAULT=1, COUNT=0, TOP=0; PC does not advance on later ticks.
- DEPTH_BITS=2: PUSH 1 x4, then DUP -> COUNT=4 held, FAULT=1, no RAM_WE on the DUP.
- Assert RST during RDWAIT of ADD -> all outputs 0 within the same cycle; re-run from PC=0 gives the same result as the first scenario.
